// File: rtl/muldiv_unit.sv
// ----------------------------------------------------------------------------
// muldiv_unit : iterative MULT/MULTU/DIV/DIVU unit driving architectural HI/LO
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic             o_div_by_zero
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  localparam logic [5:0] c_last = 6'(WIDTH - 1);

  state_t             r_state, w_next;
  logic [5:0]         r_cnt;
  logic               r_is_div, r_neg, r_rem_neg, r_dz;
  logic [WIDTH-1:0]   r_bmag;
  logic [2*WIDTH-1:0] r_acc;
  logic               r_busy, r_done, r_div_by_zero;
  logic [WIDTH-1:0]   r_hi, r_lo;

  logic               w_signed, w_is_div, w_b_zero;
  logic [WIDTH-1:0]   w_amag, w_bmag, w_hi, w_lo;
  logic [WIDTH:0]     w_msum, w_shift;
  logic               w_ge;
  logic [WIDTH-1:0]   w_diff, w_rem_next;
  logic [2*WIDTH-1:0] w_iter, w_prod;
  logic [WIDTH-1:0]   w_quot, w_rem;

  assign w_signed = ~i_op[0];
  assign w_is_div = i_op[1];
  assign w_b_zero = (i_b == '0);
  assign w_amag   = (w_signed && i_a[WIDTH-1]) ? -i_a : i_a;
  assign w_bmag   = (w_signed && i_b[WIDTH-1]) ? -i_b : i_b;

  // Accumulator halves: multiply keeps {partial product, multiplier},
  // divide keeps {partial remainder, dividend/quotient}.
  assign w_hi       = r_acc[2*WIDTH-1:WIDTH];
  assign w_lo       = r_acc[WIDTH-1:0];
  assign w_msum     = {1'b0, w_hi} + (w_lo[0] ? {1'b0, r_bmag} : '0);
  assign w_shift    = {w_hi, w_lo[WIDTH-1]};
  assign w_ge       = (w_shift >= {1'b0, r_bmag});
  assign w_diff     = w_shift[WIDTH-1:0] - r_bmag;
  assign w_rem_next = w_ge ? w_diff : w_shift[WIDTH-1:0];
  assign w_iter     = r_is_div ? {w_rem_next, w_lo[WIDTH-2:0], w_ge}
                               : {w_msum, w_lo[WIDTH-1:1]};

  assign w_prod = r_neg ? -r_acc : r_acc;
  assign w_quot = r_neg ? -w_lo : w_lo;
  assign w_rem  = r_rem_neg ? -w_hi : w_hi;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (i_start) w_next = (w_is_div && w_b_zero) ? S_FIX : S_RUN;
      S_RUN:  if (r_cnt == c_last) w_next = S_FIX;
      S_FIX:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt         <= '0;
      r_is_div      <= 1'b0;
      r_neg         <= 1'b0;
      r_rem_neg     <= 1'b0;
      r_dz          <= 1'b0;
      r_bmag        <= '0;
      r_acc         <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_div_by_zero <= 1'b0;
      r_hi          <= '0;
      r_lo          <= '0;
    end else begin
      r_busy <= (w_next != S_IDLE);
      r_done <= (r_state == S_FIX);
      case (r_state)
        S_IDLE: if (i_start) begin
          r_is_div      <= w_is_div;
          r_neg         <= w_signed && (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
          r_rem_neg     <= w_signed && i_a[WIDTH-1];
          r_dz          <= w_is_div && w_b_zero;
          r_div_by_zero <= 1'b0;
          r_cnt         <= '0;
          r_bmag        <= w_is_div ? w_bmag : w_amag;
          // Divide-by-zero keeps the raw dividend so FIX can return it in HI.
          r_acc         <= {{WIDTH{1'b0}},
                            w_is_div ? (w_b_zero ? i_a : w_amag) : w_bmag};
        end
        S_RUN: begin
          r_acc <= w_iter;
          r_cnt <= r_cnt + 6'd1;
        end
        S_FIX: begin
          if (r_dz) begin
            r_hi          <= w_lo;
            r_lo          <= '1;
            r_div_by_zero <= 1'b1;
          end else if (r_is_div) begin
            r_hi <= w_rem;
            r_lo <= w_quot;
          end else begin
            r_hi <= w_prod[2*WIDTH-1:WIDTH];
            r_lo <= w_prod[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_hi          = r_hi;
  assign o_lo          = r_lo;
  assign o_div_by_zero = r_div_by_zero;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// ----------------------------------------------------------------------------
// tb_muldiv_unit : scoreboard bench for muldiv_unit against an arithmetic model
// Revision       : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_start;
  logic [1:0]  i_op;
  logic [31:0] i_a, i_b;
  logic        o_busy, o_done, o_div_by_zero;
  logic [31:0] o_hi, o_lo;

  int checks = 0;
  int errors = 0;
  logic [64:0] sb[$];   // {div_by_zero, hi, lo}

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_op(i_op),
    .i_a(i_a), .i_b(i_b), .o_busy(o_busy), .o_done(o_done),
    .o_hi(o_hi), .o_lo(o_lo), .o_div_by_zero(o_div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [64:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint      sa = longint'($signed(a));
    longint      sb = longint'($signed(b));
    logic [63:0] p;
    logic [31:0] q, r;
    if (op[1] && b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
    case (op)
      2'd0: begin p = 64'(sa * sb); return {1'b0, p}; end
      2'd1: begin p = {32'd0, a} * {32'd0, b}; return {1'b0, p}; end
      2'd2: begin q = 32'(sa / sb); r = 32'(sa % sb); end
      default: begin q = a / b; r = a % b; end
    endcase
    return {1'b0, r, q};
  endfunction

  // Called at a negedge; returns just after the accepting edge E0 with
  // scrambled inputs so later operand changes are exercised.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    i_op = op; i_a = a; i_b = b; i_start = 1'b1;
    sb.push_back(model(op, a, b));
    @(posedge clk);
    #1;
    i_start = 1'b0;
    i_op = 2'($urandom); i_a = $urandom; i_b = $urandom;
  endtask

  task automatic wait_done(input int exp_lat, input string name);
    int          n = 0;
    logic [31:0] h0 = o_hi;
    logic [31:0] l0 = o_lo;
    logic        stable = 1'b1;
    logic        first_busy = 1'b0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) first_busy = o_busy;
      if (!o_done && (o_hi !== h0 || o_lo !== l0)) stable = 1'b0;
    end while (!o_done && n < 40);
    chk({name, "_latency"}, 64'(n), 64'(exp_lat));
    chk({name, "_busy_start"}, 64'(first_busy), 64'd1);
    chk({name, "_busy_end"}, 64'(o_busy), 64'd0);
    chk({name, "_hilo_hold"}, 64'(stable), 64'd1);
  endtask

  // Scoreboard monitor: every done pulse consumes one expected result.
  initial begin
    logic [64:0] e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && o_done === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 expected no pending result");
        end else begin
          e = sb.pop_front();
          chk("mon_hi", 64'(o_hi), 64'(e[63:32]));
          chk("mon_lo", 64'(o_lo), 64'(e[31:0]));
          chk("mon_dz", 64'(o_div_by_zero), 64'(e[64]));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    logic [1:0]  op;
    logic [31:0] a, b;
    rst_n = 1'b0; i_start = 1'b0; i_op = 2'd0; i_a = '0; i_b = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_done", 64'(o_done), 64'd0);
    chk("rst_hi", 64'(o_hi), 64'd0);
    chk("rst_lo", 64'(o_lo), 64'd0);
    chk("rst_dz", 64'(o_div_by_zero), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF); wait_done(34, "multu_max");
    chk("multu_max_hi", 64'(o_hi), 64'hFFFF_FFFE);
    chk("multu_max_lo", 64'(o_lo), 64'h0000_0001);
    issue(2'd0, 32'hFFFF_FFFD, 32'd5); wait_done(34, "mult_neg");
    chk("mult_neg_hi", 64'(o_hi), 64'hFFFF_FFFF);
    chk("mult_neg_lo", 64'(o_lo), 64'hFFFF_FFF1);
    issue(2'd0, 32'h8000_0000, 32'h8000_0000); wait_done(34, "mult_min");
    chk("mult_min_hi", 64'(o_hi), 64'h4000_0000);
    chk("mult_min_lo", 64'(o_lo), 64'h0);
    issue(2'd2, 32'hFFFF_FFF9, 32'd2); wait_done(34, "div_neg");
    chk("div_neg_lo", 64'(o_lo), 64'hFFFF_FFFD);
    chk("div_neg_hi", 64'(o_hi), 64'hFFFF_FFFF);
    issue(2'd3, 32'd100, 32'd7); wait_done(34, "divu");
    chk("divu_lo", 64'(o_lo), 64'd14);
    chk("divu_hi", 64'(o_hi), 64'd2);
    issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF); wait_done(34, "div_ovf");
    chk("div_ovf_lo", 64'(o_lo), 64'h8000_0000);
    chk("div_ovf_hi", 64'(o_hi), 64'h0);
    issue(2'd3, 32'd100, 32'd0); wait_done(2, "dz");
    chk("dz_flag", 64'(o_div_by_zero), 64'd1);
    chk("dz_hi", 64'(o_hi), 64'd100);
    chk("dz_lo", 64'(o_lo), 64'hFFFF_FFFF);
    issue(2'd1, 32'd2, 32'd3);
    chk("dz_cleared", 64'(o_div_by_zero), 64'd0);
    wait_done(34, "after_dz");
    chk("after_dz_lo", 64'(o_lo), 64'd6);

    // Start pulses mid-run and in FIX must be ignored.
    issue(2'd1, 32'd3, 32'd4);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (o_done) break;
      if (n == 5 || n == 32 || n == 33) begin
        i_start = 1'b1; i_op = 2'($urandom); i_a = $urandom; i_b = $urandom;
      end else begin
        i_start = 1'b0;
      end
    end while (n < 40);
    chk("ignore_latency", 64'(n), 64'd34);
    chk("ignore_lo", 64'(o_lo), 64'd12);
    issue(2'd1, 32'd5, 32'd7);
    chk("b2b_busy", 64'(o_busy), 64'd1);
    wait_done(34, "b2b");
    chk("b2b_lo", 64'(o_lo), 64'd35);

    // Asynchronous reset in the middle of a divide.
    issue(2'd2, 32'hFFFF_1234, 32'd77);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(o_busy), 64'd0);
    chk("arst_done", 64'(o_done), 64'd0);
    chk("arst_hi", 64'(o_hi), 64'd0);
    chk("arst_lo", 64'(o_lo), 64'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(2'd3, 32'd9, 32'd3); wait_done(34, "post_rst");
    chk("post_rst_lo", 64'(o_lo), 64'd3);
    chk("post_rst_hi", 64'(o_hi), 64'd0);

    for (int k = 0; k < 25; k++) begin
      op = 2'($urandom_range(0, 3));
      a  = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 15);
        2:       b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      issue(op, a, b);
      wait_done((op[1] && b == 32'd0) ? 2 : 34, "rand");
    end

    repeat (2) @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
